// File: rtl/mem_stage_pkg.sv
// Shared encodings and decode helpers for the memory stage.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
    OP_SB, OP_SH, OP_SW,
    OP_LWL, OP_LWR, OP_SWL, OP_SWR
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  function automatic logic is_std_op(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_lr_op(input logic [3:0] op);
    return (op >= OP_LWL) && (op <= OP_SWR);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
    if (op inside {OP_LH, OP_LHU, OP_SH}) return off[0];
    if (op inside {OP_LW, OP_SW})         return off != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store strobes/lane replication and load extract/extend.
// LWL/LWR/SWL/SWR lane rules exist only when MEM_UNALIGNED_LWLR_EN is defined.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] st_in,
  input  logic [31:0] ld_in,
  output logic [3:0]  we,
  output logic [31:0] st_dat,
  output logic [31:0] ld_dat
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

`ifdef MEM_UNALIGNED_LWLR_EN
  logic [4:0] sh_fwd;
  logic [4:0] sh_inv;
  assign sh_fwd = {off, 3'b000};
  assign sh_inv = {~off, 3'b000};
`endif

  assign ld_b = ld_in[{off, 3'b000} +: 8];
  assign ld_h = ld_in[{off[1], 4'b0000} +: 16];

  always_comb begin
    we     = 4'b0000;
    st_dat = ZERO_WORD;
    ld_dat = ZERO_WORD;
    case (op)
      OP_LB:  ld_dat = {{24{ld_b[7]}}, ld_b};
      OP_LBU: ld_dat = {24'h0, ld_b};
      OP_LH:  ld_dat = {{16{ld_h[15]}}, ld_h};
      OP_LHU: ld_dat = {16'h0, ld_h};
      OP_LW:  ld_dat = ld_in;
      OP_SB: begin
        we     = 4'b0001 << off;
        st_dat = {4{st_in[7:0]}};
      end
      OP_SH: begin
        we     = 4'b0011 << off;
        st_dat = {2{st_in[15:0]}};
      end
      OP_SW: begin
        we     = 4'b1111;
        st_dat = st_in;
      end
`ifdef MEM_UNALIGNED_LWLR_EN
      // Little-endian: LWL/SWL touch bytes 0..off, LWR/SWR touch bytes off..3.
      OP_LWL: ld_dat = (ld_in << sh_inv) | (st_in & ~(32'hFFFF_FFFF << sh_inv));
      OP_LWR: ld_dat = (ld_in >> sh_fwd) | (st_in & ~(32'hFFFF_FFFF >> sh_fwd));
      OP_SWL: begin
        we     = 4'b1111 >> ~off;
        st_dat = st_in >> sh_inv;
      end
      OP_SWR: begin
        we     = 4'b1111 << off;
        st_dat = st_in << sh_fwd;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: one outstanding data-RAM access, stall raised from issue until DONE (>=1 BUSY cycle).
// Access is held on the bus until ram_ready or MAX_WAIT timeout; MEM_UNALIGNED_LWLR_EN enables LWL/LWR/SWL/SWR.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [31:0]       result_in,
  input  logic              write_reg_en_in,
  input  logic [4:0]        write_reg_addr_in,
  input  logic              write_hilo_en_in,
  input  logic [31:0]       write_hi_data_in,
  input  logic [31:0]       write_lo_data_in,
  input  logic              flush,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready,
  output logic              mem_stall_request,
  output logic              addr_error,
  output logic              bus_timeout,
  output logic [31:0]       result_out,
  output logic              write_reg_en_out,
  output logic [4:0]        write_reg_addr_out,
  output logic              write_hilo_en_out,
  output logic [31:0]       write_hi_data_out,
  output logic [31:0]       write_lo_data_out
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              drop_q, drop_d;
  logic              to_q, to_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [3:0]        al_op, al_we;
  logic [1:0]        al_off;
  logic [31:0]       al_st, al_ld;
  logic [ADDR_W-1:0] word_addr;
  logic              op_acc, op_kill;

  assign word_addr = {mem_addr[ADDR_W-1:2], 2'b00};
  assign al_op     = (state_q == ST_IDLE) ? mem_op : op_q;
  assign al_off    = (state_q == ST_IDLE) ? mem_addr[1:0] : off_q;

  mem_lane_align u_align (
    .op     (al_op),
    .off    (al_off),
    .st_in  (mem_wdata),
    .ld_in  (rdata_q),
    .we     (al_we),
    .st_dat (al_st),
    .ld_dat (al_ld)
  );

  always_comb begin
`ifdef MEM_UNALIGNED_LWLR_EN
    op_acc  = is_std_op(mem_op) || is_lr_op(mem_op);
    op_kill = 1'b0;
`else
    op_acc  = is_std_op(mem_op);
    op_kill = is_lr_op(mem_op);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    drop_d  = drop_q;
    to_d    = to_q;
    op_d    = op_q;
    off_d   = off_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    ram_en             = 1'b0;
    ram_we             = 4'b0000;
    ram_addr           = '0;
    ram_wdata          = ZERO_WORD;
    mem_stall_request  = 1'b0;
    addr_error         = 1'b0;
    bus_timeout        = 1'b0;
    result_out         = result_in;
    write_reg_en_out   = write_reg_en_in;
    write_reg_addr_out = write_reg_addr_in;
    write_hilo_en_out  = write_hilo_en_in;
    write_hi_data_out  = write_hi_data_in;
    write_lo_data_out  = write_lo_data_in;

    case (state_q)
      ST_IDLE: begin
        if (op_kill) begin
          write_reg_en_out = 1'b0;
        end else if (op_acc && misaligned(mem_op, mem_addr[1:0])) begin
          addr_error       = !flush;
          write_reg_en_out = 1'b0;
        end else if (op_acc && !flush) begin
          ram_en            = 1'b1;
          ram_we            = al_we;
          ram_addr          = word_addr;
          ram_wdata         = al_st;
          mem_stall_request = 1'b1;
          write_reg_en_out  = 1'b0;
          state_d           = ST_BUSY;
          cnt_d             = '0;
          drop_d            = 1'b0;
          to_d              = 1'b0;
          op_d              = mem_op;
          off_d             = mem_addr[1:0];
          we_d              = al_we;
          addr_d            = word_addr;
          wdata_d           = al_st;
        end
      end
      ST_BUSY: begin
        ram_en            = 1'b1;
        ram_we            = we_q;
        ram_addr          = addr_q;
        ram_wdata         = wdata_q;
        mem_stall_request = 1'b1;
        write_reg_en_out  = 1'b0;
        // The bus cannot abort, so a flush here only marks the result for discard.
        if (flush) drop_d = 1'b1;
        if (ram_ready) begin
          rdata_d = ram_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        bus_timeout = to_q;
        if (is_load(op_q)) result_out = al_ld;
        if (!is_load(op_q) || to_q) write_reg_en_out = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush || (state_q == ST_DONE && drop_q)) begin
      write_reg_en_out  = 1'b0;
      write_hilo_en_out = 1'b0;
    end

    if (rst == RST_ENABLE) begin
      ram_en             = 1'b0;
      ram_we             = 4'b0000;
      ram_addr           = '0;
      ram_wdata          = ZERO_WORD;
      mem_stall_request  = 1'b0;
      addr_error         = 1'b0;
      bus_timeout        = 1'b0;
      result_out         = ZERO_WORD;
      write_reg_en_out   = 1'b0;
      write_reg_addr_out = 5'd0;
      write_hilo_en_out  = 1'b0;
      write_hi_data_out  = ZERO_WORD;
      write_lo_data_out  = ZERO_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= ZERO_WORD;
      drop_q  <= 1'b0;
      to_q    <= 1'b0;
      op_q    <= '0;
      off_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
      to_q    <= to_d;
      op_q    <= op_d;
      off_q   <= off_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;

  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 255;

  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4,
                         LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, result_in, write_hi_data_in, write_lo_data_in;
  logic              write_reg_en_in, write_hilo_en_in, flush;
  logic [4:0]        write_reg_addr_in;
  logic              ram_en, ram_ready, mem_stall_request, addr_error, bus_timeout;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata, result_out, write_hi_data_out, write_lo_data_out;
  logic              write_reg_en_out, write_hilo_en_out;
  logic [4:0]        write_reg_addr_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_op             (mem_op),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .result_in          (result_in),
    .write_reg_en_in    (write_reg_en_in),
    .write_reg_addr_in  (write_reg_addr_in),
    .write_hilo_en_in   (write_hilo_en_in),
    .write_hi_data_in   (write_hi_data_in),
    .write_lo_data_in   (write_lo_data_in),
    .flush              (flush),
    .ram_en             (ram_en),
    .ram_we             (ram_we),
    .ram_addr           (ram_addr),
    .ram_wdata          (ram_wdata),
    .ram_rdata          (ram_rdata),
    .ram_ready          (ram_ready),
    .mem_stall_request  (mem_stall_request),
    .addr_error         (addr_error),
    .bus_timeout        (bus_timeout),
    .result_out         (result_out),
    .write_reg_en_out   (write_reg_en_out),
    .write_reg_addr_out (write_reg_addr_out),
    .write_hilo_en_out  (write_hilo_en_out),
    .write_hi_data_out  (write_hi_data_out),
    .write_lo_data_out  (write_lo_data_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [3:0] op, input int o, input logic [31:0] w);
    byte     b;
    shortint h;
    case (op)
      LB:      begin b = w[8*o +: 8];  return 32'(b); end
      LBU:     return 32'(w[8*o +: 8]);
      LH:      begin h = w[8*o +: 16]; return 32'(h); end
      LHU:     return 32'(w[8*o +: 16]);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [3:0] op, input int o);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (i >= o) && (i < o + op_size(op));
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wd);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % op_size(op)) +: 8];
    return d;
  endfunction

  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int dly, input bit fl_idle, input bit fl_busy);
    int          size, o, stalls;
    bit          ld, st, mis;
    logic [31:0] res_in, hi_in, lo_in;
    logic        reg_en_in, hilo_in;
    logic [4:0]  ra;
    size      = op_size(op);
    o         = int'(addr[1:0]);
    ld        = (op >= LB) && (op <= LW);
    st        = (op >= SB) && (op <= SW);
    mis       = (size != 0) && ((o % size) != 0);
    res_in    = $urandom;
    hi_in     = $urandom;
    lo_in     = $urandom;
    reg_en_in = ($urandom_range(0, 3) != 0);
    hilo_in   = 1'($urandom_range(0, 1));
    ra        = 5'($urandom);

    mem_op = op; mem_addr = addr; mem_wdata = wd; ram_rdata = rd;
    result_in = res_in; write_reg_en_in = reg_en_in; write_reg_addr_in = ra;
    write_hilo_en_in = hilo_in; write_hi_data_in = hi_in; write_lo_data_in = lo_in;
    flush     = fl_idle && !mis;
    ram_ready = (size == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);

    if (size == 0) begin
      check("pt_result", result_out, res_in);
      check("pt_reg_en", write_reg_en_out, (op == NONE) && reg_en_in && !flush);
      check("pt_reg_addr", write_reg_addr_out, ra);
      check("pt_hilo_en", write_hilo_en_out, hilo_in && !flush);
      check("pt_hi", write_hi_data_out, hi_in);
      check("pt_ram_en", ram_en, 0);
      check("pt_stall", mem_stall_request, 0);
    end else if (mis) begin
      check("mis_addr_error", addr_error, 1);
      check("mis_ram_en", ram_en, 0);
      check("mis_ram_we", ram_we, 0);
      check("mis_reg_en", write_reg_en_out, 0);
      check("mis_stall", mem_stall_request, 0);
    end else if (flush) begin
      check("fl_ram_en", ram_en, 0);
      check("fl_reg_en", write_reg_en_out, 0);
      check("fl_hilo_en", write_hilo_en_out, 0);
      check("fl_stall", mem_stall_request, 0);
    end else begin
      stalls = mem_stall_request ? 1 : 0;
      check("iss_ram_en", ram_en, 1);
      check("iss_ram_addr", ram_addr, {addr[31:2], 2'b00});
      check("iss_ram_we", ram_we, st ? store_strobe(op, o) : 4'b0000);
      if (st) check("iss_ram_wdata", ram_wdata, store_data(op, wd));
      for (int k = 1; k <= dly; k++) begin
        step();
        flush     = fl_busy && (k == 1);
        ram_ready = (k == dly);
        @(negedge clk);
        if (mem_stall_request) stalls++;
        if (k == dly) begin
          check("busy_ram_en", ram_en, 1);
          check("busy_ram_addr", ram_addr, {addr[31:2], 2'b00});
          check("busy_ram_we", ram_we, st ? store_strobe(op, o) : 4'b0000);
        end
      end
      step();
      flush = 1'b0; ram_ready = 1'b0;
      @(negedge clk);
      check("stall_cycles", stalls, dly + 1);
      check("done_stall", mem_stall_request, 0);
      check("done_ram_en", ram_en, 0);
      if (ld) check("done_result", result_out, load_value(op, o, rd));
      check("done_reg_en", write_reg_en_out, ld && reg_en_in && !fl_busy);
      check("done_hilo_en", write_hilo_en_out, hilo_in && !fl_busy);
      check("done_lo", write_lo_data_out, lo_in);
    end
    step();
    flush = 1'b0; ram_ready = 1'b0;
  endtask

  task automatic do_timeout();
    int stalls = 0;
    mem_op = LW; mem_addr = 32'h0000_0040; write_reg_en_in = 1'b1;
    flush = 1'b0; ram_ready = 1'b0;
    @(negedge clk);
    while (mem_stall_request && stalls < 2 * MAX_WAIT + 10) begin
      stalls++;
      step();
      @(negedge clk);
    end
    check("to_stall_cycles", stalls, MAX_WAIT + 1);
    check("to_pulse", bus_timeout, 1);
    check("to_reg_en", write_reg_en_out, 0);
    step();
    mem_op = NONE; result_in = 32'h0000_0077;
    @(negedge clk);
    check("to_pulse_end", bus_timeout, 0);
    check("to_idle_stall", mem_stall_request, 0);
    check("to_idle_result", result_out, 32'h0000_0077);
    step();
  endtask

  initial begin
    logic [3:0] rop;
    rst = 1'b0; mem_op = NONE; mem_addr = '0; mem_wdata = '0; result_in = '0;
    write_reg_en_in = 1'b0; write_reg_addr_in = '0; write_hilo_en_in = 1'b0;
    write_hi_data_in = '0; write_lo_data_in = '0; flush = 1'b0;
    ram_rdata = '0; ram_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    result_in = 32'hFFFF_FFFF; write_reg_en_in = 1'b1; write_hilo_en_in = 1'b1;
    write_hi_data_in = 32'hFFFF_FFFF; write_reg_addr_in = 5'd31;
    @(negedge clk);
    check("rst_result", result_out, 0);
    check("rst_reg_en", write_reg_en_out, 0);
    check("rst_reg_addr", write_reg_addr_out, 0);
    check("rst_hilo_en", write_hilo_en_out, 0);
    check("rst_hi", write_hi_data_out, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_stall", mem_stall_request, 0);
    step();
    rst = 1'b1;

    do_access(LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    do_access(LB,  32'h0000_0103, 32'h0,         32'h80FF_0000, 1, 1'b0, 1'b0);
    do_access(LBU, 32'h0000_0103, 32'h0,         32'h80FF_0000, 2, 1'b0, 1'b0);
    do_access(SH,  32'h0000_0202, 32'h1234_ABCD, 32'h0,         1, 1'b0, 1'b0);
    do_access(LW,  32'h0000_0101, 32'h0,         32'h0,         1, 1'b0, 1'b0);
    do_access(LH,  32'h0000_0106, 32'h0,         32'h8001_7FFF, 2, 1'b0, 1'b1);
    do_access(SW,  32'h0000_0108, 32'h5555_AAAA, 32'h0,         1, 1'b1, 1'b0);
    do_timeout();

    // Reset while an access is in flight.
    mem_op = LW; mem_addr = 32'h0000_0300; flush = 1'b0; ram_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstbusy_ram_en", ram_en, 0);
    check("rstbusy_stall", mem_stall_request, 0);
    step();
    rst = 1'b1; mem_op = NONE; result_in = 32'h0000_0005; write_reg_en_in = 1'b1;
    @(negedge clk);
    check("post_rst_result", result_out, 32'h0000_0005);
    check("post_rst_reg_en", write_reg_en_out, 1);
    check("post_rst_ram_en", ram_en, 0);
    check("post_rst_stall", mem_stall_request, 0);
    step();

    for (int n = 0; n < 300; n++) begin
      rop = 4'($urandom_range(0, 12));
      do_access(rop, $urandom, $urandom, $urandom, $urandom_range(1, 4),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
